inv_shift_rows_serial: RTL

INV_SHIFT_ROWS_SERIAL -- requirements
Module: inv_shift_rows_serial

---
 rtl/inv_shift_rows_serial.sv | 75 +++++++
 1 files changed

// File: rtl/inv_shift_rows_serial.sv
// inv_shift_rows_serial: AES InvShiftRows over a 32-bit column stream,
// double-buffered so one state loads while the previous one drains.
module inv_shift_rows_serial #(
    parameter int DATA_W = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        err_frame
);
    logic [DATA_W-1:0] state_buf [2];
    logic [DATA_W-1:0] rd_buf;
    logic [1:0]        full, full_n;
    logic              wr_ptr, rd_ptr, wr_n;
    logic [1:0]        in_cnt, out_cnt;
    logic              in_fire, out_fire, in_done, out_done;
    logic [31:0]       col;

    assign in_fire  = s_valid && s_ready;
    assign out_fire = m_valid && m_ready;
    assign in_done  = in_fire && in_cnt == 2'd3;
    assign out_done = out_fire && out_cnt == 2'd3;
    assign wr_n     = wr_ptr ^ in_done;
    assign rd_buf   = state_buf[rd_ptr];
    assign m_valid  = full[rd_ptr];
    assign m_last   = m_valid && out_cnt == 2'd3;
    assign m_data   = m_valid ? col : '0;

    // Completion and release always hit different buffers, so both apply.
    always_comb begin
        full_n = full;
        if (in_done) full_n[wr_ptr] = 1'b1;
        if (out_done) full_n[rd_ptr] = 1'b0;
    end

    // Row r of output column c comes from input column (c - r) mod 4.
    always_comb begin
        col = '0;
        for (int r = 0; r < 4; r++)
            col[24-8*r +: 8] = rd_buf[32*(2'(out_cnt - 2'(r))) + 24 - 8*r +: 8];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full      <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            s_ready   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            full    <= full_n;
            wr_ptr  <= wr_n;
            rd_ptr  <= rd_ptr ^ out_done;
            s_ready <= !full_n[wr_n];
            if (in_fire) begin
                in_cnt <= in_cnt + 2'd1;
                if (s_last != (in_cnt == 2'd3)) err_frame <= 1'b1;
            end
            if (out_fire) out_cnt <= out_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) state_buf[wr_ptr][32*in_cnt +: 32] <= s_data;
    end
endmodule
